// File: rtl/eprisc_fetch_queue_if.sv
// Fetch-stage bus bundle: ROM address/data side plus the decoder valid/ready side.
// The master modport is the fetch unit; the slave modport is the ROM/decoder/execute environment.
interface eprisc_fetch_queue_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] oRomAddr;
  logic              oRomEnable;
  logic [31:0]       iRomData;
  logic              iRedirect;
  logic [ADDR_W-1:0] iRedirectPC;
  logic [31:0]       oInstr;
  logic [ADDR_W-1:0] oInstrPC;
  logic              oInstrValid;
  logic              iInstrReady;

  modport master (
    output oRomAddr, oRomEnable, oInstr, oInstrPC, oInstrValid,
    input  iRomData, iRedirect, iRedirectPC, iInstrReady
  );

  modport slave (
    input  oRomAddr, oRomEnable, oInstr, oInstrPC, oInstrValid,
    output iRomData, iRedirect, iRedirectPC, iInstrReady
  );
endinterface

// File: rtl/eprisc_fetch_queue.sv
// epRISC fetch stage: drives the 1-cycle ROM and buffers fetched words in a small prefetch
// queue feeding the decoder; branch redirects flush everything fetched down the old path.
module eprisc_fetch_queue #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic iClk,
  input  logic iReset,
  eprisc_fetch_queue_if.master bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  typedef enum logic [1:0] {S_RESET, S_RUN, S_FULL} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              pending_q, pending_d;
  logic [31:0]       data_q [DEPTH];
  logic [31:0]       data_d [DEPTH];
  logic [ADDR_W-1:0] tag_q  [DEPTH];
  logic [ADDR_W-1:0] tag_d  [DEPTH];
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;

  logic              push, pop, issue;
  logic [OCC_W-1:0]  occ_q, occ_d;

  // Next-state: redirect flushes and retargets; otherwise push/pop/issue proceed together.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    pending_d = 1'b0;
    data_d    = data_q;
    tag_d     = tag_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    count_d   = count_q;

    push  = pending_q;
    pop   = valid_q & bus.iInstrReady;
    occ_q = OCC_W'(count_q) + OCC_W'(pending_q);
    issue = (state_q == S_RUN) && (occ_q < DEPTH_OCC);

    if (bus.iRedirect) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
      pc_d    = bus.iRedirectPC;
      state_d = S_RUN;
    end else begin
      if (push) begin
        data_d[wr_q] = bus.iRomData;
        tag_d[wr_q]  = pend_pc_q;
        wr_d         = PTR_W'(wr_q + 1'b1);
      end
      if (pop) begin
        rd_d = PTR_W'(rd_q + 1'b1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (issue) begin
        pending_d = 1'b1;
        pend_pc_d = pc_q;
        pc_d      = ADDR_W'(pc_q + 1'b1);
      end
      occ_d = OCC_W'(count_d) + OCC_W'(pending_d);
      case (state_q)
        S_RESET: state_d = S_RUN;
        S_RUN:   if (occ_d == DEPTH_OCC) state_d = S_FULL;
        S_FULL:  if (occ_d <  DEPTH_OCC) state_d = S_RUN;
        default: state_d = S_RUN;
      endcase
    end

    if (bus.iRedirect) begin
      occ_d = '0;
    end
    valid_d = (count_d != '0);
    instr_d = data_d[rd_d];
    ipc_d   = tag_d[rd_d];
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q   <= S_RESET;
      pc_q      <= ADDR_W'(RESET_PC);
      pend_pc_q <= '0;
      pending_q <= 1'b0;
      rd_q      <= '0;
      wr_q      <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      ipc_q     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      pending_q <= pending_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      ipc_q     <= ipc_d;
      data_q    <= data_d;
      tag_q     <= tag_d;
    end
  end

  // ROM enable is exactly the in-flight flag, so it is high only in the capture cycle.
  assign bus.oRomAddr    = pc_q;
  assign bus.oRomEnable  = pending_q;
  assign bus.oInstr      = instr_q;
  assign bus.oInstrPC    = ipc_q;
  assign bus.oInstrValid = valid_q;
endmodule

// File: tb/tb_eprisc_fetch_queue.sv
// Directed bench for eprisc_fetch_queue: 1-cycle ROM model with mem[a] = A500_0000 | a.
module tb_eprisc_fetch_queue;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] rom_q;

  always #5 clk = ~clk;

  eprisc_fetch_queue_if #(.ADDR_W(8)) bus ();

  eprisc_fetch_queue #(.ADDR_W(8), .DEPTH(4), .RESET_PC(0)) dut (
    .iClk   (clk),
    .iReset (rst),
    .bus    (bus)
  );

  always_ff @(posedge clk) rom_q <= 32'hA500_0000 | {24'h0, bus.oRomAddr};
  assign bus.iRomData = bus.oRomEnable ? rom_q : 32'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.iRedirect = 1'b1; bus.iRedirectPC = 8'h77; bus.iInstrReady = 1'b1;
    tick(); tick();
    n_checks++;
    if ({bus.oInstrValid, bus.oRomEnable, bus.oRomAddr} !== {1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_ctl: got v/en/addr %b/%b/%h want 0/0/00", bus.oInstrValid, bus.oRomEnable, bus.oRomAddr);
    end
    n_checks++;
    if ({bus.oInstr, bus.oInstrPC} !== {32'h0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h want 00000000/00", bus.oInstr, bus.oInstrPC);
    end
    bus.iRedirect = 1'b0;
  endtask

  task automatic test_startup();
    rst = 1'b0; bus.iInstrReady = 1'b1;
    tick();
    n_checks++;
    if ({bus.oInstrValid, bus.oRomEnable, bus.oRomAddr} !== {1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL start_e0: got %b/%b/%h want 0/0/00", bus.oInstrValid, bus.oRomEnable, bus.oRomAddr);
    end
    tick();
    n_checks++;
    if ({bus.oInstrValid, bus.oRomEnable, bus.oRomAddr} !== {1'b0, 1'b1, 8'h01}) begin
      n_fail++;
      $display("FAIL start_e1: got %b/%b/%h want 0/1/01", bus.oInstrValid, bus.oRomEnable, bus.oRomAddr);
    end
    tick();
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if ({bus.oInstrValid, bus.oInstr, bus.oInstrPC} !== {1'b1, 32'hA500_0000 | k, 8'(k)}) begin
        n_fail++;
        $display("FAIL start_stream%0d: got %b/%h/%h want 1/%h/%h", k, bus.oInstrValid, bus.oInstr,
                 bus.oInstrPC, 32'hA500_0000 | k, 8'(k));
      end
      tick();
    end
  endtask

  task automatic test_fill_drain();
    rst = 1'b1; tick(); tick();
    rst = 1'b0; bus.iInstrReady = 1'b0;
    repeat (6) tick();
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if ({bus.oInstrValid, bus.oRomEnable, bus.oRomAddr, bus.oInstr, bus.oInstrPC} !==
          {1'b1, 1'b0, 8'h04, 32'hA500_0000, 8'h00}) begin
        n_fail++;
        $display("FAIL fill_park%0d: got %b/%b/%h/%h/%h want 1/0/04/a5000000/00", s, bus.oInstrValid,
                 bus.oRomEnable, bus.oRomAddr, bus.oInstr, bus.oInstrPC);
      end
      repeat (3) tick();
    end
    bus.iInstrReady = 1'b1;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if ({bus.oInstrValid, bus.oInstr, bus.oInstrPC} !== {1'b1, 32'hA500_0000 | k, 8'(k)}) begin
        n_fail++;
        $display("FAIL drain%0d: got %b/%h/%h want 1/%h/%h", k, bus.oInstrValid, bus.oInstr,
                 bus.oInstrPC, 32'hA500_0000 | k, 8'(k));
      end
      tick();
    end
  endtask

  task automatic test_redirect_flush();
    rst = 1'b1; tick(); tick();
    rst = 1'b0; bus.iInstrReady = 1'b0;
    repeat (5) tick();
    n_checks++;
    if ({bus.oInstrValid, bus.oRomEnable, bus.oRomAddr} !== {1'b1, 1'b1, 8'h04}) begin
      n_fail++;
      $display("FAIL flush_pre: got %b/%b/%h want 1/1/04", bus.oInstrValid, bus.oRomEnable, bus.oRomAddr);
    end
    bus.iRedirect = 1'b1; bus.iRedirectPC = 8'h40;
    tick();
    bus.iRedirect = 1'b0; bus.iInstrReady = 1'b1;
    n_checks++;
    if ({bus.oInstrValid, bus.oRomEnable, bus.oRomAddr} !== {1'b0, 1'b0, 8'h40}) begin
      n_fail++;
      $display("FAIL flush_r0: got %b/%b/%h want 0/0/40", bus.oInstrValid, bus.oRomEnable, bus.oRomAddr);
    end
    tick();
    n_checks++;
    if ({bus.oInstrValid, bus.oRomEnable, bus.oRomAddr} !== {1'b0, 1'b1, 8'h41}) begin
      n_fail++;
      $display("FAIL flush_r1: got %b/%b/%h want 0/1/41", bus.oInstrValid, bus.oRomEnable, bus.oRomAddr);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({bus.oInstrValid, bus.oInstr, bus.oInstrPC} !== {1'b1, 32'hA500_0040 + k, 8'(8'h40 + k)}) begin
        n_fail++;
        $display("FAIL flush_tgt%0d: got %b/%h/%h want 1/%h/%h", k, bus.oInstrValid, bus.oInstr,
                 bus.oInstrPC, 32'hA500_0040 + k, 8'(8'h40 + k));
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [7:0] pc;
    bus.iRedirect = 1'b1; bus.iRedirectPC = 8'hFE; bus.iInstrReady = 1'b1;
    tick();
    bus.iRedirect = 1'b0;
    n_checks++;
    if ({bus.oInstrValid, bus.oRomAddr} !== {1'b0, 8'hFE}) begin
      n_fail++;
      $display("FAIL wrap_r0: got %b/%h want 0/fe", bus.oInstrValid, bus.oRomAddr);
    end
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      pc = 8'(8'hFE + k);
      n_checks++;
      if ({bus.oInstrValid, bus.oInstr, bus.oInstrPC} !== {1'b1, 32'hA500_0000 | {24'h0, pc}, pc}) begin
        n_fail++;
        $display("FAIL wrap%0d: got %b/%h/%h want 1/%h/%h", k, bus.oInstrValid, bus.oInstr,
                 bus.oInstrPC, 32'hA500_0000 | {24'h0, pc}, pc);
      end
      tick();
    end
  endtask

  task automatic test_coincident();
    n_checks++;
    if ({bus.oInstrValid, bus.oRomEnable} !== 2'b11) begin
      n_fail++;
      $display("FAIL coin_pre: got v/en %b/%b want 1/1", bus.oInstrValid, bus.oRomEnable);
    end
    bus.iRedirect = 1'b1; bus.iRedirectPC = 8'h20; bus.iInstrReady = 1'b1;
    tick();
    bus.iRedirect = 1'b0;
    n_checks++;
    if ({bus.oInstrValid, bus.oRomEnable, bus.oRomAddr} !== {1'b0, 1'b0, 8'h20}) begin
      n_fail++;
      $display("FAIL coin_r0: got %b/%b/%h want 0/0/20", bus.oInstrValid, bus.oRomEnable, bus.oRomAddr);
    end
    tick();
    n_checks++;
    if ({bus.oInstrValid, bus.oRomEnable, bus.oRomAddr} !== {1'b0, 1'b1, 8'h21}) begin
      n_fail++;
      $display("FAIL coin_r1: got %b/%b/%h want 0/1/21", bus.oInstrValid, bus.oRomEnable, bus.oRomAddr);
    end
    tick();
    n_checks++;
    if ({bus.oInstrValid, bus.oRomAddr, bus.oInstr, bus.oInstrPC} !== {1'b1, 8'h22, 32'hA500_0020, 8'h20}) begin
      n_fail++;
      $display("FAIL coin_r2: got %b/%h/%h/%h want 1/22/a5000020/20", bus.oInstrValid, bus.oRomAddr,
               bus.oInstr, bus.oInstrPC);
    end
    tick();
    n_checks++;
    if ({bus.oInstrValid, bus.oInstr, bus.oInstrPC} !== {1'b1, 32'hA500_0021, 8'h21}) begin
      n_fail++;
      $display("FAIL coin_r3: got %b/%h/%h want 1/a5000021/21", bus.oInstrValid, bus.oInstr, bus.oInstrPC);
    end
  endtask

  task automatic test_reset_midstream();
    bus.iInstrReady = 1'b0;
    repeat (8) tick();
    n_checks++;
    if ({bus.oInstrValid, bus.oRomEnable} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_full: got v/en %b/%b want 1/0", bus.oInstrValid, bus.oRomEnable);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({bus.oInstrValid, bus.oRomEnable, bus.oRomAddr, bus.oInstr, bus.oInstrPC} !==
        {1'b0, 1'b0, 8'h00, 32'h0, 8'h00}) begin
      n_fail++;
      $display("FAIL mid_reset: got %b/%b/%h/%h/%h want 0/0/00/00000000/00", bus.oInstrValid,
               bus.oRomEnable, bus.oRomAddr, bus.oInstr, bus.oInstrPC);
    end
    rst = 1'b0; bus.iInstrReady = 1'b1;
    tick(); tick(); tick();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({bus.oInstrValid, bus.oInstr, bus.oInstrPC} !== {1'b1, 32'hA500_0000 | k, 8'(k)}) begin
        n_fail++;
        $display("FAIL mid_restart%0d: got %b/%h/%h want 1/%h/%h", k, bus.oInstrValid, bus.oInstr,
                 bus.oInstrPC, 32'hA500_0000 | k, 8'(k));
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.iRedirect = 1'b0;
    bus.iRedirectPC = 8'h00;
    bus.iInstrReady = 1'b0;
    test_reset();
    test_startup();
    test_fill_drain();
    test_redirect_flush();
    test_wrap();
    test_coincident();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
